// File: rtl/nfloat_pkg.sv
// nfloat_pkg: shared definitions for the IEEE-754 -> FloPoCo nfloat converters.
//   EXC_*          : 2-bit nfloat exception codes
//   exp_width()    : IEEE exponent width (wE) for a given operand width
//   frac_width()   : IEEE fraction width (wF) for a given operand width
// Only operand widths 32 and 64 are meaningful; other widths are rejected by the
// instantiating top.
package nfloat_pkg;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

   function automatic int unsigned exp_width(input int unsigned data_width);
      return (data_width == 64) ? 11 : 8;
   endfunction

   function automatic int unsigned frac_width(input int unsigned data_width);
      return (data_width == 64) ? 52 : 23;
   endfunction

endpackage

// File: rtl/ieee2nfloat_classify.sv
// ieee2nfloat_classify: combinational IEEE-754 word -> nfloat word.
//   ieee_i      : IEEE operand {sign, exp[wE-1:0], frac[wF-1:0]}
//   nfloat_o    : nfloat word {exc[1:0], sign, exp[wE-1:0], frac[wF-1:0]}
//   is_nan_o    : operand is a NaN
//   is_inf_o    : operand is +/- infinity
//   is_sub_o    : operand is a subnormal (flushed to signed zero)
// Exponent bias is kept as-is; only the exception field is synthesised.
module ieee2nfloat_classify
   import nfloat_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] ieee_i,
   output logic [DATA_WIDTH+1:0] nfloat_o,
   output logic                  is_nan_o,
   output logic                  is_inf_o,
   output logic                  is_sub_o
);

   localparam int unsigned WE = exp_width(DATA_WIDTH);
   localparam int unsigned WF = frac_width(DATA_WIDTH);

   logic          sign;
   logic [WE-1:0] exp_f;
   logic [WF-1:0] frac_f;
   logic          exp_zero;
   logic          exp_ones;
   logic          frac_zero;

   assign sign      = ieee_i[DATA_WIDTH-1];
   assign exp_f     = ieee_i[DATA_WIDTH-2 -: WE];
   assign frac_f    = ieee_i[WF-1:0];
   assign exp_zero  = (exp_f == '0);
   assign exp_ones  = &exp_f;
   assign frac_zero = (frac_f == '0);

   always_comb begin
      nfloat_o = '0;
      is_nan_o = 1'b0;
      is_inf_o = 1'b0;
      is_sub_o = 1'b0;
      if (exp_zero) begin
         // Zero and subnormal both become signed zero.
         nfloat_o = {EXC_ZERO, sign, {(DATA_WIDTH-1){1'b0}}};
         is_sub_o = !frac_zero;
      end else if (exp_ones) begin
         if (frac_zero) begin
            nfloat_o = {EXC_INF, sign, {(DATA_WIDTH-1){1'b0}}};
            is_inf_o = 1'b1;
         end else begin
            // NaN is canonicalised: sign and payload dropped.
            nfloat_o = {EXC_NAN, {DATA_WIDTH{1'b0}}};
            is_nan_o = 1'b1;
         end
      end else begin
         nfloat_o = {EXC_NORMAL, ieee_i};
      end
   end

endmodule

// File: rtl/ieee2nfloat_pipe.sv
// ieee2nfloat_pipe: elastic two-stage IEEE-754 -> nfloat converter.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   ins        : IEEE operand           ins_valid / ins_ready   : input handshake
//   outs       : nfloat word            outs_valid / outs_ready : output handshake
//   status     : sticky {nan_seen, inf_seen, subnormal_flushed}, only present when
//                IEEE2NFLOAT_STATUS_EN is defined
// Stage A holds the raw IEEE word, stage B the converted word. Latency 2, one word
// per cycle; outs_ready reaches ins_ready combinationally so a full pipe never bubbles.
module ieee2nfloat_pipe
   import nfloat_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH+1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
`ifdef IEEE2NFLOAT_STATUS_EN
   ,
   output logic [2:0]            status
`endif
);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
      $fatal(1, "ieee2nfloat_pipe: DATA_WIDTH must be 32 or 64");
   end

   localparam int unsigned NW = DATA_WIDTH + 2;

   logic                  valid_a_q, valid_a_d;
   logic                  valid_b_q, valid_b_d;
   logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
   logic [NW-1:0]         data_b_q, data_b_d;

   logic                  ready_b;
   logic                  load_a;
   logic                  load_b;
   logic [NW-1:0]         conv;
   logic                  conv_nan;
   logic                  conv_inf;
   logic                  conv_sub;

   ieee2nfloat_classify #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_classify (
      .ieee_i   (data_a_q),
      .nfloat_o (conv),
      .is_nan_o (conv_nan),
      .is_inf_o (conv_inf),
      .is_sub_o (conv_sub)
   );

   assign ready_b   = !valid_b_q || outs_ready;
   assign ins_ready = !valid_a_q || ready_b;
   assign load_a    = ins_valid && ins_ready;
   assign load_b    = valid_a_q && ready_b;

   always_comb begin
      valid_a_d = valid_a_q;
      valid_b_d = valid_b_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      if (load_a) begin
         valid_a_d = 1'b1;
         data_a_d  = ins;
      end else if (load_b) begin
         valid_a_d = 1'b0;
      end
      if (load_b) begin
         valid_b_d = 1'b1;
         data_b_d  = conv;
      end else if (outs_ready) begin
         valid_b_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         data_a_q  <= '0;
         data_b_q  <= '0;
      end else begin
         valid_a_q <= valid_a_d;
         valid_b_q <= valid_b_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
      end
   end

   assign outs       = data_b_q;
   assign outs_valid = valid_b_q;

`ifdef IEEE2NFLOAT_STATUS_EN
   logic [2:0] status_q, status_d;

   // Flags accumulate on the A->B transfer, so stalled words are not counted twice.
   always_comb begin
      status_d = status_q;
      if (load_b) begin
         status_d = status_q | {conv_nan, conv_inf, conv_sub};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

   assign status = status_q;
`else
   logic unused_flags;
   assign unused_flags = conv_nan ^ conv_inf ^ conv_sub;
`endif

endmodule

// File: tb/tb_ieee2nfloat_pipe.sv
// Directed bench for ieee2nfloat_pipe (32-bit instance plus a 64-bit instance).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ieee2nfloat_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic [33:0] outs;
   logic        outs_valid;
   logic        outs_ready;

   logic [63:0] ins64;
   logic        ins_valid64;
   logic        ins_ready64;
   logic [65:0] outs64;
   logic        outs_valid64;
   logic        outs_ready64;

`ifdef IEEE2NFLOAT_STATUS_EN
   logic [2:0] status;
   logic [2:0] status64;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] vin_q[$];
   logic [33:0] vexp_q[$];

   always #5 clk = ~clk;

   ieee2nfloat_pipe #(
      .DATA_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
`ifdef IEEE2NFLOAT_STATUS_EN
      ,
      .status     (status)
`endif
   );

   ieee2nfloat_pipe #(
      .DATA_WIDTH (64)
   ) dut64 (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins64),
      .ins_valid  (ins_valid64),
      .ins_ready  (ins_ready64),
      .outs       (outs64),
      .outs_valid (outs_valid64),
      .outs_ready (outs_ready64)
`ifdef IEEE2NFLOAT_STATUS_EN
      ,
      .status     (status64)
`endif
   );

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streams vin_q back-to-back with outs_ready=1; result k must appear after edge k+1.
   task automatic run_stream(input string tag);
      int n;
      n = vin_q.size();
      for (int c = 0; c <= n; c++) begin
         ins_valid = (c < n);
         if (c < n) begin
            ins = vin_q[c];
            check({tag, " ins_ready"}, 66'(ins_ready), 66'(1'b1));
         end
         step();
         if (c >= 1) begin
            check({tag, " outs_valid"}, 66'(outs_valid), 66'(1'b1));
            check({tag, " outs"}, 66'(outs), 66'(vexp_q[c-1]));
         end
      end
      ins_valid = 1'b0;
      step();
      check({tag, " drained"}, 66'(outs_valid), 66'(1'b0));
      vin_q.delete();
      vexp_q.delete();
   endtask

   initial begin
      logic [7:0]  e;
      logic [22:0] f;
      logic        s;

      rst          = 1'b0;
      ins          = '0;
      ins_valid    = 1'b0;
      outs_ready   = 1'b1;
      ins64        = '0;
      ins_valid64  = 1'b0;
      outs_ready64 = 1'b1;

      // Reset state
      repeat (3) step();
      check("reset outs", 66'(outs), 66'(0));
      check("reset outs_valid", 66'(outs_valid), 66'(1'b0));
      rst = 1'b1;
      check("post-reset ins_ready", 66'(ins_ready), 66'(1'b1));
`ifdef IEEE2NFLOAT_STATUS_EN
      check("reset status", 66'(status), 66'(3'b000));
`endif
      step();
      check("idle outs_valid", 66'(outs_valid), 66'(1'b0));

      // 1.0: latency check
      ins = 32'h3F80_0000;
      ins_valid = 1'b1;
      step();
      ins_valid = 1'b0;
      check("1.0 not yet valid", 66'(outs_valid), 66'(1'b0));
      step();
      check("1.0 outs_valid", 66'(outs_valid), 66'(1'b1));
      check("1.0 outs", 66'(outs), 66'(34'h1_3F80_0000));
      step();
      check("1.0 drained", 66'(outs_valid), 66'(1'b0));
`ifdef IEEE2NFLOAT_STATUS_EN
      check("status after normal", 66'(status), 66'(3'b000));
`endif

      // Special values back-to-back
      vin_q.push_back(32'h8000_0000); vexp_q.push_back(34'h0_8000_0000);
      vin_q.push_back(32'hFF80_0000); vexp_q.push_back(34'h2_8000_0000);
      vin_q.push_back(32'h7F80_0000); vexp_q.push_back(34'h2_0000_0000);
      vin_q.push_back(32'h7FC0_0000); vexp_q.push_back(34'h3_0000_0000);
      vin_q.push_back(32'hFFC0_0001); vexp_q.push_back(34'h3_0000_0000);
      vin_q.push_back(32'h0000_0001); vexp_q.push_back(34'h0_0000_0000);
      vin_q.push_back(32'h807F_FFFF); vexp_q.push_back(34'h0_8000_0000);
      vin_q.push_back(32'h0080_0000); vexp_q.push_back(34'h1_0080_0000);
      vin_q.push_back(32'hFF7F_FFFF); vexp_q.push_back(34'h1_FF7F_FFFF);
      run_stream("special");
`ifdef IEEE2NFLOAT_STATUS_EN
      check("status after specials", 66'(status), 66'(3'b111));
`endif

      // Backpressure
      ins = 32'h4000_0000;
      ins_valid = 1'b1;
      step();
      outs_ready = 1'b0;
      ins = 32'h4040_0000;
      check("bp accept second", 66'(ins_ready), 66'(1'b1));
      step();
      ins = 32'h4080_0000;
      check("bp full ins_ready", 66'(ins_ready), 66'(1'b0));
      check("bp first outs", 66'(outs), 66'(34'h1_4000_0000));
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp stall outs", 66'(outs), 66'(34'h1_4000_0000));
         check("bp stall valid", 66'(outs_valid), 66'(1'b1));
         check("bp stall ins_ready", 66'(ins_ready), 66'(1'b0));
      end
      outs_ready = 1'b1;
      #1;
      check("bp release ins_ready", 66'(ins_ready), 66'(1'b1));
      step();
      ins_valid = 1'b0;
      check("bp second outs", 66'(outs), 66'(34'h1_4040_0000));
      check("bp second valid", 66'(outs_valid), 66'(1'b1));
      step();
      check("bp third outs", 66'(outs), 66'(34'h1_4080_0000));
      check("bp third valid", 66'(outs_valid), 66'(1'b1));
      step();
      check("bp no duplicate", 66'(outs_valid), 66'(1'b0));

      // 16 random normals back-to-back
      for (int i = 0; i < 16; i++) begin
         s = 1'($urandom);
         e = 8'($urandom_range(254, 1));
         f = 23'($urandom);
         vin_q.push_back({s, e, f});
         vexp_q.push_back({2'b01, s, e, f});
      end
      run_stream("normals");

      // Reset mid-stream
      ins = 32'h40A0_0000;
      ins_valid = 1'b1;
      step();
      ins = 32'h40C0_0000;
      step();
      check("pre-reset outs_valid", 66'(outs_valid), 66'(1'b1));
      #2;
      rst = 1'b0;
      #1;
      check("async reset outs_valid", 66'(outs_valid), 66'(1'b0));
      check("async reset outs", 66'(outs), 66'(0));
`ifdef IEEE2NFLOAT_STATUS_EN
      check("async reset status", 66'(status), 66'(3'b000));
`endif
      ins_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("post-reset no stale word", 66'(outs_valid), 66'(1'b0));
      vin_q.push_back(32'h4100_0000); vexp_q.push_back(34'h1_4100_0000);
      run_stream("after reset");

      // 64-bit instance
      ins64 = 64'h3FF0_0000_0000_0000;
      ins_valid64 = 1'b1;
      step();
      ins64 = 64'h7FF8_0000_0000_0000;
      step();
      ins_valid64 = 1'b0;
      check("w64 1.0 valid", 66'(outs_valid64), 66'(1'b1));
      check("w64 1.0", outs64, 66'h1_3FF0_0000_0000_0000);
      step();
      check("w64 nan", outs64, 66'h3_0000_0000_0000_0000);
      step();
      check("w64 drained", 66'(outs_valid64), 66'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ieee2nfloat_pipe.md
Name: ieee2nfloat_pipe

Overview:
Elastic, pipelined IEEE-754 to FloPoCo-nfloat converter that sits directly upstream of the floating-point divider/arith units. Accepts one IEEE word per handshake and produces the (DATA_WIDTH+2)-bit nfloat word consumed by the divider core. Registering the conversion removes the combinational converter from the join-to-core timing path. Throughput is 1 word/cycle; it stalls under backpressure without loss.

Parameters:
DATA_WIDTH, 32, IEEE operand width; legal values 32 (wE=8, wF=23) and 64 (wE=11, wF=52); any other value is a fatal elaboration error.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
ins  input  DATA_WIDTH  IEEE-754 operand
ins_valid  input  1  operand valid
ins_ready  output  1  stage accepts operand
outs  output  DATA_WIDTH+2  nfloat {exc[1:0], sign, exp[wE-1:0], frac[wF-1:0]}
outs_valid  output  1  result valid
outs_ready  input  1  consumer accepts result

Behaviour:
- Two register stages: A (captured IEEE word + valid_a), B (converted nfloat + valid_b).
- Reset (rst=0, async assert, sync release): valid_a=valid_b=0, data regs 0; so outs=0, outs_valid=0, ins_ready=1 after release.
- Ready chain: ready_b = !valid_b | outs_ready; ins_ready = !valid_a | ready_b. Combinational outs_ready->ins_ready path is intentional (no bubble).
- A loads ins when ins_valid & ins_ready; otherwise valid_a clears when its word moves to B and nothing new arrives.
- B loads convert(A) when valid_a & ready_b; valid_b clears when outs_ready & no new load.
- Data regs load only on a transfer; held stable while outs_valid & !outs_ready (no data change while stalled).
- Latency: 2 cycles from accepted ins to outs_valid with no backpressure; full rate back-to-back.
- Conversion (e=exponent field, m=mantissa field, s=sign):
  e==0, m==0 -> exc=00 (zero), sign=s, exp=0, frac=0
  e==0, m!=0 -> subnormal flushed to zero: exc=00, sign=s, exp=0, frac=0
  e==all-ones, m==0 -> exc=10 (inf), sign=s, exp=0, frac=0
  e==all-ones, m!=0 -> exc=11 (NaN), sign=0, exp=0, frac=0
  otherwise -> exc=01, sign=s, exp=e, frac=m (same bias, no rebias)
- Full pipeline + outs_ready=0: ins_ready=0; no word dropped or duplicated.
- Simultaneous B drain and A->B move and new input capture in one cycle is legal and is the steady state.
- rst asserted mid-stream: all in-flight words discarded immediately; no partial output.

Optional Feature:
Macro IEEE2NFLOAT_STATUS_EN. Defined: adds output status [2:0] = sticky {nan_seen, inf_seen, subnormal_flushed}, set when the corresponding word transfers A->B, cleared only by reset. Not defined: port absent, no extra state; conversion identical.

Decomposition:
- Package nfloat_pkg: exception code constants (EXC_ZERO=2'b00, EXC_NORMAL=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11) and functions deriving wE/wF from DATA_WIDTH.
- One combinational sub-module, ieee2nfloat_classify (IEEE word -> nfloat word + status bits), instantiated between A and B; reusable by the rhs path and other arith ops.

Test Plan:
- 32-bit, outs_ready=1: ins 0x3F800000 (1.0) -> two cycles later outs=0x1_3F800000, outs_valid=1.
- Specials: 0x80000000 -> 0x0_80000000; 0xFF800000 -> 0x2_80000000; 0x7FC00000 -> 0x3_00000000; 0x00000001 -> 0x0_00000000 (status[0]=1 with STATUS_EN).
- Backpressure: stream 0x40000000,0x40400000,0x40800000 with outs_ready=0 from cycle 2 -> ins_ready=0 after 2 accepted; release -> outputs 0x1_40000000,0x1_40400000,0x1_40800000 in order, none lost or repeated; outs stable while stalled.
- Back-to-back 16 random normals, outs_ready=1 -> one result per cycle, latency 2, bit-exact vs model.
- Reset mid-stream: rst=0 with valid_a=valid_b=1 -> outs_valid=0 asynchronously, outs=0, status=0; first post-release word emerges 2 cycles after acceptance.
- DATA_WIDTH=64: 0x3FF0000000000000 -> outs=0x1_3FF0000000000000.
